// File: rtl/mips_fetch_pkg.sv
// Purpose: shared types/constants for the instruction-fetch front end.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
// Contents: PC width, FSM state encoding (BOOT/RUN/STALL/SQUASH) and the
// power-of-two wrap-mask helper applied to every PC the fetch unit produces.
package mips_fetch_pkg;

    localparam int PC_W = 32;

    // Fetch FSM encoding. The state is observational only; no output depends on it.
    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STALL  = 2'd2;
    localparam logic [1:0] ST_SQUASH = 2'd3;

    // Wrap a word index into a power-of-two memory; upper bits come out zero.
    function automatic logic [PC_W-1:0] wrap_pc(input logic [PC_W-1:0] pc,
                                                 input int unsigned     depth);
        wrap_pc = pc & PC_W'(depth - 1);
    endfunction

endpackage

// File: rtl/pc_incr_wrap.sv
// Purpose: next sequential PC, wrapped modulo the instruction memory depth.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
// Ports: pc (current word index), next_pc (wrap(pc + PC_STEP)).
module pc_incr_wrap
    import mips_fetch_pkg::*;
#(
    parameter int unsigned PC_STEP   = 1,
    parameter int unsigned MEM_DEPTH = 512
) (
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] next_pc
);

    assign next_pc = wrap_pc(pc + PC_W'(PC_STEP), MEM_DEPTH);

endmodule

// File: rtl/pc_fetch_unit.sv
// Purpose: PC owner and fetch tracker in front of a 1-cycle registered instruction memory.
// Latency: pc_o -> fetch_pc_o/fetch_valid_o is exactly 1 cycle, aligned with memory data.
// Backpressure: stall_i replays the current word (memory re-reads it); redirect_i wins and squashes one slot.
// Ports: clk, rst_n (async active-low); stall_i, redirect_i, redirect_pc_i in;
//        pc_o (memory address, combinational), fetch_pc_o, fetch_pc1_o, fetch_valid_o out.
// Optional: define FETCH_PERF_EN to add saturating fetch_cnt_o / stall_cnt_o counters.
module pc_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int unsigned     MEM_DEPTH = 512,
    parameter int unsigned     PC_STEP   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] fetch_pc_o,
    output logic [PC_W-1:0] fetch_pc1_o,
    output logic            fetch_valid_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_cnt_o,
    output logic [31:0]     stall_cnt_o
`endif
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] fetch_pc_q;
    logic            fetch_valid_q;
    logic [1:0]      state;
    logic [1:0]      state_d;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_redir;

    assign pc_redir = wrap_pc(redirect_pc_i, MEM_DEPTH);

    pc_incr_wrap #(.PC_STEP(PC_STEP), .MEM_DEPTH(MEM_DEPTH)) u_pc_incr (
        .pc      (pc_q),
        .next_pc (pc_seq)
    );

    pc_incr_wrap #(.PC_STEP(PC_STEP), .MEM_DEPTH(MEM_DEPTH)) u_link_incr (
        .pc      (fetch_pc_q),
        .next_pc (fetch_pc1_o)
    );

    // On a pure stall the memory is re-addressed with the word it already shows,
    // so its registered output stays intact. A redirect must not be masked by a
    // concurrent stall, hence the ~redirect_i term.
    assign pc_o          = (stall_i & ~redirect_i) ? fetch_pc_q : pc_q;
    assign fetch_pc_o    = fetch_pc_q;
    assign fetch_valid_o = fetch_valid_q;

    always_comb begin
        state_d = state;
        if (redirect_i)
            state_d = ST_SQUASH;
        else if (stall_i)
            state_d = ST_STALL;
        else
            state_d = ST_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= wrap_pc(RESET_PC, MEM_DEPTH);
            fetch_pc_q    <= wrap_pc(RESET_PC, MEM_DEPTH);
            fetch_valid_q <= 1'b0;
            state         <= ST_BOOT;
        end else begin
            state <= state_d;
            if (redirect_i) begin
                // The word arriving next cycle was fetched down the wrong path:
                // mark it invalid and keep fetch_pc_q as-is (it is not consumed).
                pc_q          <= pc_redir;
                fetch_valid_q <= 1'b0;
            end else if (!stall_i) begin
                fetch_pc_q    <= pc_q;
                pc_q          <= pc_seq;
                fetch_valid_q <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (!redirect_i && !stall_i && (fetch_cnt_q != '1))
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (!redirect_i && stall_i && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Purpose: directed self-checking bench for pc_fetch_unit with a 512-word registered memory model.
// Latency: memory model has 1-cycle read latency, no read enable.
// Backpressure: stall/redirect driven from directed vectors.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o;
    logic [31:0] fetch_pc_o;
    logic [31:0] fetch_pc1_o;
    logic        fetch_valid_o;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;
`endif

    logic [31:0] mem [512];
    logic [31:0] inst;

    int n_chk = 0;
    int n_err = 0;

    pc_fetch_unit #(.RESET_PC(32'd0), .MEM_DEPTH(512), .PC_STEP(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc_o),
        .fetch_pc_o    (fetch_pc_o),
        .fetch_pc1_o   (fetch_pc1_o),
        .fetch_valid_o (fetch_valid_o)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) inst <= mem[pc_o[8:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, "_valid"}, {31'd0, fetch_valid_o}, 32'd1);
        check({tag, "_pc"}, fetch_pc_o, pc);
        check({tag, "_inst"}, inst, ins);
    endtask

    // Reset release followed by three sequential fetches.
    task automatic boot_sequence(input string tag);
        check({tag, "_boot_valid"}, {31'd0, fetch_valid_o}, 32'd0);
        check({tag, "_boot_pco"}, pc_o, 32'd0);
        tick(); expect_fetch({tag, "_f0"}, 32'd0, 32'hA000);
        tick(); expect_fetch({tag, "_f1"}, 32'd1, 32'hA001);
        tick(); expect_fetch({tag, "_f2"}, 32'd2, 32'hA002);
        check({tag, "_pc1_at2"}, fetch_pc1_o, 32'd3);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = i + 32'hA000;
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
        #1;
        check("rst_valid", {31'd0, fetch_valid_o}, 32'd0);
        check("rst_fetch_pc", fetch_pc_o, 32'd0);
        check("rst_pc_o", pc_o, 32'd0);
        check("rst_pc1", fetch_pc1_o, 32'd1);
        tick(); tick();
        rst_n = 1'b1;

        // Sequential fetch after reset.
        boot_sequence("s1");
        tick(); tick(); tick();
        expect_fetch("s2_pre", 32'd5, 32'hA005);

        // Three-cycle stall at fetch_pc 5.
        stall_i = 1'b1;
        #1 check("s2_pco_stall", pc_o, 32'd5);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_fetch($sformatf("s2_hold%0d", k), 32'd5, 32'hA005);
            check($sformatf("s2_pco%0d", k), pc_o, 32'd5);
        end
        stall_i = 1'b0;
        #1 check("s2_pco_rel", pc_o, 32'd6);
        tick(); expect_fetch("s2_after", 32'd6, 32'hA006);
        tick(); expect_fetch("s3_pre", 32'd7, 32'hA007);

        // Redirect to 100 at fetch_pc 7.
        redirect_i = 1'b1; redirect_pc_i = 32'd100;
        tick();
        redirect_i = 1'b0;
        #1;
        check("s3_bubble", {31'd0, fetch_valid_o}, 32'd0);
        check("s3_pco", pc_o, 32'd100);
        tick(); expect_fetch("s3_target", 32'd100, 32'hA064);

        // Redirect with simultaneous stall: redirect wins.
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'd200;
        #1 check("s4_pco_same", pc_o, 32'd101);
        tick();
        redirect_i = 1'b0; stall_i = 1'b0;
        #1;
        check("s4_bubble", {31'd0, fetch_valid_o}, 32'd0);
        check("s4_pco", pc_o, 32'd200);
        tick(); expect_fetch("s4_target", 32'd200, 32'hA0C8);

        // Wrap through the top of memory.
        redirect_i = 1'b1; redirect_pc_i = 32'd510;
        tick();
        redirect_i = 1'b0;
        tick(); expect_fetch("s5_510", 32'd510, 32'hA1FE);
        check("s5_pc1_510", fetch_pc1_o, 32'd511);
        tick(); expect_fetch("s5_511", 32'd511, 32'hA1FF);
        check("s5_pc1_511", fetch_pc1_o, 32'd0);
        check("s5_pco_wrap", pc_o, 32'd0);
        tick(); expect_fetch("s5_0", 32'd0, 32'hA000);

        // Out-of-range redirect target wraps; then stall during the bubble.
        redirect_i = 1'b1; redirect_pc_i = 32'h205;
        tick();
        redirect_i = 1'b0;
        stall_i = 1'b1;
        tick();
        check("s5_stall_bubble", {31'd0, fetch_valid_o}, 32'd0);
        check("s5_stall_bubble_pc", fetch_pc_o, 32'd0);
        stall_i = 1'b0;
        #1 check("s5_pco_wrapped", pc_o, 32'd5);
        tick(); expect_fetch("s5_wrapped", 32'd5, 32'hA005);

        // Asynchronous reset in the middle of a stall.
        stall_i = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("s6_valid", {31'd0, fetch_valid_o}, 32'd0);
        check("s6_fetch_pc", fetch_pc_o, 32'd0);
        check("s6_pc_o", pc_o, 32'd0);
        check("s6_pc1", fetch_pc1_o, 32'd1);
`ifdef FETCH_PERF_EN
        check("s6_fetch_cnt", fetch_cnt_o, 32'd0);
        check("s6_stall_cnt", stall_cnt_o, 32'd0);
`endif
        stall_i = 1'b0;
        tick();
        rst_n = 1'b1;
        boot_sequence("s6r");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
